mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: request-driven memory with READ/WRITE and INC/DEC read-modify-write.
// Define MEM_ZERO_FLAG_EN to add the zero output (mem_out == 0).
module mem_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_SRC  = 4,
  parameter int NUM_ADDR = 4,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int SEL_W   = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 mem_op,
  input  logic [SRC_W-1:0]           mem_src,
  input  logic [SEL_W-1:0]           mem_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_ADDR*ADDR_W-1:0] addr_data,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          mem_out
`ifdef MEM_ZERO_FLAG_EN
  ,
  output logic                       zero
`endif
);

  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_DEC   = 3'b100;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RMW  = 1'b1;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [0:0]        state;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_old;
  logic              rmw_dec;
  logic [DATA_W-1:0] rmw_new;

  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              accept;
  logic              is_read;
  logic              is_write;
  logic              is_rmw;

  // Out-of-range selects fall through to the zero default.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (mem_src == SRC_W'(i))
        sel_data = src_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_ADDR; i++)
      if (mem_addr == SEL_W'(i))
        sel_addr = addr_data[i*ADDR_W +: ADDR_W];
  end

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign is_read   = (mem_op == OP_READ);
  assign is_write  = (mem_op == OP_WRITE);
  assign is_rmw    = (mem_op == OP_INC) | (mem_op == OP_DEC);
  assign rmw_new   = rmw_dec ? rmw_old - DATA_W'(1)
                           : rmw_old + DATA_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      mem_out   <= '0;
      rmw_addr  <= '0;
      rmw_old   <= '0;
      rmw_dec   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_RMW) begin
        mem_out   <= rmw_new;
        rsp_valid <= 1'b1;
        state     <= S_IDLE;
      end else if (accept) begin
        unique case (1'b1)
          is_read: begin
            mem_out   <= mem[sel_addr];
            rsp_valid <= 1'b1;
          end
          is_write: begin
            mem_out   <= sel_data;
            rsp_valid <= 1'b1;
          end
          is_rmw: begin
            rmw_addr <= sel_addr;
            rmw_old  <= mem[sel_addr];
            rmw_dec  <= (mem_op == OP_DEC);
            state    <= S_RMW;
          end
          default: ;
        endcase
      end
    end
  end

  // Reset drops state to IDLE at once, so a pending RMW write never lands.
  always_ff @(posedge clk) begin
    if (state == S_RMW)
      mem[rmw_addr] <= rmw_new;
    else if (accept && is_write)
      mem[sel_addr] <= sel_data;
  end

`ifdef MEM_ZERO_FLAG_EN
  assign zero = (mem_out == '0);
`else
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against an array model.
// Build with or without MEM_ZERO_FLAG_EN.
module tb_mem_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int NS  = 3;
  localparam int NA  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        mem_op = 3'b000;
  logic [1:0]        mem_src = 2'd0;
  logic [1:0]        mem_addr = 2'd0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NA*AW-1:0]  addr_data = '0;
  logic              rsp_valid;
  logic [DW-1:0]     mem_out;
`ifdef MEM_ZERO_FLAG_EN
  logic              zero;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mm [256];
  logic [DW-1:0] exp_out;
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  mem_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .NUM_ADDR(NA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .mem_op(mem_op),
    .mem_src(mem_src),
    .mem_addr(mem_addr),
    .src_data(src_data),
    .addr_data(addr_data),
    .rsp_valid(rsp_valid),
    .mem_out(mem_out)
`ifdef MEM_ZERO_FLAG_EN
    ,
    .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Drive one request; unselected channels carry random noise.
  task automatic set_req(input logic [2:0] op, input int sidx, input int aidx,
                         input logic [DW-1:0] wd, input logic [AW-1:0] wa,
                         output logic [AW-1:0] eff_a, output logic [DW-1:0] eff_d);
    req_valid = 1'b1;
    mem_op    = op;
    mem_src   = 2'(sidx);
    mem_addr  = 2'(aidx);
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = 8'($urandom);
    for (int i = 0; i < NA; i++) addr_data[i*AW +: AW] = 8'($urandom);
    if (sidx < NS) src_data[sidx*DW +: DW] = wd;
    if (aidx < NA) addr_data[aidx*AW +: AW] = wa;
    eff_a = (aidx < NA) ? wa : 8'h00;
    eff_d = (sidx < NS) ? wd : 8'h00;
  endtask

  // Reference behaviour: what each op does to the cell and to the output.
  task automatic model_op(input logic [2:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    case (op)
      3'b001: exp_out = mm[a];
      3'b010: begin mm[a] = d; exp_out = d; end
      3'b011: begin mm[a] = 8'((int'(mm[a]) + 1) % 256); exp_out = mm[a]; end
      3'b100: begin mm[a] = 8'((int'(mm[a]) + 255) % 256); exp_out = mm[a]; end
      default: ;
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b want 0", rsp_valid); end
    checks++;
    if (mem_out !== 8'h00) begin errors++; $display("FAIL rst_out: got %h want 00", mem_out); end
`ifdef MEM_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b want 1", zero); end
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_out = 8'h00;
  endtask

  task automatic test_write_read;
    set_req(3'b010, 1, 0, 8'h5A, 8'h10, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp: got %b want 1", rsp_valid); end
    checks++;
    if (mem_out !== 8'h5A) begin errors++; $display("FAIL wr_out: got %h want 5a", mem_out); end
    set_req(3'b001, 2, 0, 8'h00, 8'h10, ea, ed);
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp: got %b want 1", rsp_valid); end
    checks++;
    if (mem_out !== 8'h5A) begin errors++; $display("FAIL rd_out: got %h want 5a", mem_out); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_rsp: got %b want 0", rsp_valid); end
  endtask

  task automatic test_inc_wrap;
    set_req(3'b010, 0, 1, 8'hFF, 8'h20, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    set_req(3'b011, 2, 1, 8'h00, 8'h20, ea, ed);
    model_op(3'b011, ea, ed);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL inc_ready: got %b want 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inc_rsp_mid: got %b want 0", rsp_valid); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL inc_rsp: got %b want 1", rsp_valid); end
    checks++;
    if (mem_out !== 8'h00) begin errors++; $display("FAIL inc_out: got %h want 00", mem_out); end
`ifdef MEM_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL inc_zero: got %b want 1", zero); end
`endif
    set_req(3'b001, 0, 0, 8'h00, 8'h20, ea, ed);
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (mem_out !== 8'h00) begin errors++; $display("FAIL inc_rd: got %h want 00", mem_out); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL inc_once: got %b want 0", rsp_valid); end
  endtask

  task automatic test_dec_hold;
    set_req(3'b010, 2, 2, 8'h00, 8'h21, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    set_req(3'b100, 0, 2, 8'h00, 8'h21, ea, ed);
    model_op(3'b100, ea, ed);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL dec_ready: got %b want 0", req_ready); end
    set_req(3'b001, 0, 1, 8'h00, 8'h21, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dec_rsp: got %b want 1", rsp_valid); end
    checks++;
    if (mem_out !== 8'hFF) begin errors++; $display("FAIL dec_out: got %h want ff", mem_out); end
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL held_rd_rsp: got %b want 1", rsp_valid); end
    checks++;
    if (mem_out !== 8'hFF) begin errors++; $display("FAIL held_rd_out: got %h want ff", mem_out); end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL held_rd_once: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_rmw;
    set_req(3'b010, 1, 1, 8'h07, 8'h30, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    set_req(3'b011, 1, 1, 8'h00, 8'h30, ea, ed);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (mem_out !== 8'h00) begin errors++; $display("FAIL rrst_out: got %h want 00", mem_out); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rrst_ready: got %b want 1", req_ready); end
    reset = 1'b0;
    exp_out = 8'h00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rrst_rsp: got %b want 0", rsp_valid); end
    set_req(3'b001, 0, 0, 8'h00, 8'h30, ea, ed);
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (mem_out !== 8'h07) begin errors++; $display("FAIL rrst_keep: got %h want 07", mem_out); end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nop_sel;
    set_req(3'b010, 0, 0, 8'h33, 8'h50, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    set_req(3'b111, 1, 0, 8'h99, 8'h50, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL op7_rsp: got %b want 0", rsp_valid); end
    set_req(3'b000, 1, 0, 8'h99, 8'h50, ea, ed);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL nop_rsp: got %b want 0", rsp_valid); end
    checks++;
    if (mem_out !== 8'h33) begin errors++; $display("FAIL nop_out: got %h want 33", mem_out); end
    set_req(3'b001, 2, 2, 8'h00, 8'h50, ea, ed);
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (mem_out !== 8'h33) begin errors++; $display("FAIL nop_keep: got %h want 33", mem_out); end
    set_req(3'b010, 0, 3, 8'hA7, 8'h77, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    set_req(3'b001, 0, 1, 8'h00, 8'h00, ea, ed);
    model_op(3'b001, ea, ed);
    @(negedge clk);
    checks++;
    if (mem_out !== 8'hA7) begin errors++; $display("FAIL addr_oor: got %h want a7", mem_out); end
    set_req(3'b010, 3, 0, 8'h5C, 8'h51, ea, ed);
    model_op(3'b010, ea, ed);
    @(negedge clk);
    checks++;
    if (mem_out !== 8'h00) begin errors++; $display("FAIL src_oor: got %h want 00", mem_out); end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [2:0]    op;
    logic [AW-1:0] ja;
    logic [DW-1:0] jd;
    for (int a = 0; a < 16; a++) begin
      set_req(3'b010, 0, 0, 8'($urandom), 8'(a), ea, ed);
      model_op(3'b010, ea, ed);
      @(negedge clk);
      checks++;
      if (mem_out !== exp_out) begin errors++; $display("FAIL init_out[%0d]: got %h want %h", a, mem_out, exp_out); end
    end
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      set_req(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              8'($urandom), 8'($urandom_range(0, 15)), ea, ed);
      model_op(op, ea, ed);
      @(negedge clk);
      if (op == 3'b011 || op == 3'b100) begin
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_rmw_mid[%0d]: got ready=%b rsp=%b want 0 0", n, req_ready, rsp_valid);
        end
        set_req(3'($urandom_range(1, 4)), 0, 0, 8'($urandom), 8'($urandom_range(0, 15)), ja, jd);
        @(negedge clk);
      end
      checks++;
      if (rsp_valid !== (op >= 3'b001 && op <= 3'b100)) begin
        errors++;
        $display("FAIL rnd_rsp[%0d] op=%0d: got %b want %b", n, op, rsp_valid, (op >= 3'b001 && op <= 3'b100));
      end
      checks++;
      if (mem_out !== exp_out) begin
        errors++;
        $display("FAIL rnd_out[%0d] op=%0d: got %h want %h", n, op, mem_out, exp_out);
      end
`ifdef MEM_ZERO_FLAG_EN
      checks++;
      if (zero !== (exp_out == 8'h00)) begin errors++; $display("FAIL rnd_zero[%0d]: got %b want %b", n, zero, exp_out == 8'h00); end
`endif
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_tail_rsp: got %b want 0", rsp_valid); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_inc_wrap;
    test_dec_hold;
    test_reset_rmw;
    test_nop_sel;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
